// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card power-up sequencer driving CMD0, CMD8, CMD55/ACMD41 retries, CMD2, CMD3
// Ports: clk, reset (sync, active-high); start pulse; send_en/cmd_content/sending towards the
// command sender; resp_valid/resp_data/resp_crc_err from the response receiver;
// busy/done/error/err_code status levels; rca captured from the CMD3 response.
module sd_init_seq #(
  parameter int RESP_TIMEOUT = 64,
  parameter int MAX_RETRY = 1000,
  parameter int CMD0_GAP = 8,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        send_en,
  output logic [37:0] cmd_content,
  input  logic        sending,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        resp_crc_err,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_code,
  output logic [15:0] rca
);
  typedef enum logic [3:0] {IDLE, ISSUE, TX_START, TX_END, GAP, RESP, CHECK, DONE, ERROR} state_t;
  typedef enum logic [2:0] {C0, C8, C55, A41, C2, C3} step_t;
  state_t state;
  step_t step;
  step_t nxt_step;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] retry;
  logic [31:0] resp_q;
  logic crc_q;
  logic [2:0] fail_code;
  logic go_issue;
  logic unused_resp;
  assign unused_resp = ^resp_q[15:12];
  function automatic logic [37:0] cmd_of(step_t s);
    return s == C8  ? {6'd8, 32'h0000_01AA} :
           s == C55 ? {6'd55, 32'h0} :
           s == A41 ? {6'd41, 32'h40FF_8000} :
           s == C2  ? {6'd2, 32'h0} :
           s == C3  ? {6'd3, 32'h0} : 38'd0;
  endfunction
  always_comb begin
    fail_code = 3'd0;
    if (state == TX_START && !sending && cnt == CNT_W'(RESP_TIMEOUT - 1)) fail_code = 3'd1;
    if (state == RESP && !resp_valid && cnt == CNT_W'(RESP_TIMEOUT - 1)) fail_code = 3'd2;
    if (state == CHECK)
      fail_code = crc_q && step != A41 ? 3'd3 :
                  step == C8 && resp_q[11:0] != 12'h1AA ? 3'd4 :
                  step == A41 && !resp_q[31] && retry + 1'b1 == CNT_W'(MAX_RETRY) ? 3'd5 : 3'd0;
    go_issue = (start && (state == IDLE || state == DONE || state == ERROR)) ||
               (state == GAP && cnt == CNT_W'(CMD0_GAP - 1)) ||
               (state == CHECK && fail_code == 3'd0 && step != C3);
    nxt_step = state == GAP ? C8 :
               state != CHECK ? C0 :
               step == C8 ? C55 :
               step == C55 ? A41 :
               step == A41 ? (resp_q[31] ? C2 : C55) : C3;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      step <= C0;
      cnt <= '0;
      retry <= '0;
      resp_q <= '0;
      crc_q <= 1'b0;
      send_en <= 1'b0;
      cmd_content <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= '0;
      rca <= '0;
    end else begin
      send_en <= 1'b0;
      case (state)
        IDLE, DONE, ERROR: if (start) begin
          {done, error, err_code, rca, retry} <= '0;
          busy <= 1'b1;
        end
        ISSUE: begin
          cnt <= '0;
          state <= TX_START;
        end
        TX_START: begin
          cnt <= cnt + 1'b1;
          if (sending) state <= TX_END;
        end
        // the cycle in which sending was seen low already counts toward the response window
        TX_END: if (!sending) begin
          cnt <= CNT_W'(step != C0);
          state <= step == C0 ? GAP : RESP;
        end
        GAP: cnt <= cnt + 1'b1;
        RESP: begin
          cnt <= cnt + 1'b1;
          if (resp_valid) begin
            resp_q <= resp_data;
            crc_q <= resp_crc_err;
            state <= CHECK;
          end
        end
        CHECK: begin
          if (step == A41 && !resp_q[31]) retry <= retry + 1'b1;
          if (step == C3 && !crc_q) begin
            rca <= resp_q[31:16];
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
      if (go_issue) begin
        step <= nxt_step;
        cmd_content <= cmd_of(nxt_step);
        send_en <= 1'b1;
        state <= ISSUE;
      end
      if (fail_code != 3'd0) begin
        error <= 1'b1;
        err_code <= fail_code;
        busy <= 1'b0;
        state <= ERROR;
      end
    end
  end
endmodule
